// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor. An accepted start captures both operands;
// the block then resolves one bit per clock, LSB first, through a single
// full-subtractor cell. After WIDTH cycles it publishes the difference
// (a - b mod 2^WIDTH) and the final borrow (a < b) and pulses done for
// one cycle.
//
// Timing: start accepted at edge k -> RUN on edges k+1 .. k+WIDTH ->
// DONE (done = 1) for the cycle after edge k+WIDTH -> IDLE.
//
// Ports
//   clk_in    in   1      rising-edge clock
//   rst_in    in   1      asynchronous, active-high reset
//   start_in  in   1      begin a subtraction (sampled in IDLE only)
//   a_in      in   WIDTH  minuend, unsigned
//   b_in      in   WIDTH  subtrahend, unsigned
//   busy      out  1      high from the accepted start through DONE
//   done      out  1      one-cycle pulse: diff/borrow just updated
//   diff      out  WIDTH  registered difference, held until next DONE
//   borrow    out  1      registered final borrow, held until next DONE
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    // Counter must represent WIDTH itself, so size it for WIDTH+1 values.
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;        // minuend shift register
    logic [WIDTH-1:0]   r_b;        // subtrahend shift register
    logic [WIDTH-1:0]   r_part;     // partial difference, fills from MSB
    logic               r_br;       // running borrow between bit slices
    logic [CNT_W-1:0]   r_cnt;      // bits processed so far
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow;
    logic               r_busy;
    logic               r_done;

    logic               w_d;
    logic               w_br_next;
    logic               w_last;
    logic [WIDTH-1:0]   w_part_next;

    // Full-subtractor slice on the current LSBs.
    assign w_d         = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_next   = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));
    // New bit enters at the MSB; after WIDTH shifts bit 0 sits at index 0.
    assign w_part_next = {w_d, r_part[WIDTH-1:1]};

    // NOTE: every register here uses non-blocking assignment so all state
    // updates see the pre-edge values, regardless of statement order.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            // NOTE: the datapath registers are reset too, not just control,
            // so the result outputs read 0 immediately on reset.
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_part   <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start_in) begin
                        r_a     <= a_in;
                        r_b     <= b_in;
                        r_part  <= '0;
                        r_br    <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end

                S_RUN: begin
                    r_a    <= r_a >> 1;
                    r_b    <= r_b >> 1;
                    r_part <= w_part_next;
                    r_br   <= w_br_next;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        // Publish the completed result together with done.
                        r_diff   <= w_part_next;
                        r_borrow <= w_br_next;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign diff   = r_diff;
    assign borrow = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//
// Directed and random checks for serial_subtractor at WIDTH=8 and WIDTH=16.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

    logic        clk;
    logic        rst;

    logic        start8, busy8, done8, borrow8;
    logic [7:0]  a8, b8, diff8;

    logic        start16, busy16, done16, borrow16;
    logic [15:0] a16, b16, diff16;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Expected held result of the WIDTH=8 instance (previous operation).
    logic [7:0]  prev_d = 8'h00;
    logic        prev_b = 1'b0;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk_in   (clk),
        .rst_in   (rst),
        .start_in (start8),
        .a_in     (a8),
        .b_in     (b8),
        .busy     (busy8),
        .done     (done8),
        .diff     (diff8),
        .borrow   (borrow8)
    );

    serial_subtractor #(.WIDTH(16)) u_dut16 (
        .clk_in   (clk),
        .rst_in   (rst),
        .start_in (start16),
        .a_in     (a16),
        .b_in     (b16),
        .busy     (busy16),
        .done     (done16),
        .diff     (diff16),
        .borrow   (borrow16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full WIDTH=8 operation with cycle-exact checks. Entered and left
    // at the 1 ns-after-edge point with the DUT in IDLE.
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                           input bit toggle, input string name);
        logic [7:0] ed;
        logic       eb;
        ed = a - b;
        eb = (a < b);
        start8 = 1'b1;
        a8 = a;
        b8 = b;
        tick();
        start8 = 1'b0;
        n_compared++;
        if (busy8 !== 1'b1) begin
            n_mismatched++;
            $display("FAIL %s busy_at_accept: got %b want 1", name, busy8);
        end
        for (int c = 1; c <= 8; c++) begin
            if (toggle) begin
                a8 = ~a8;
                b8 = ~b8;
            end
            tick();
            if (c < 8) begin
                n_compared++;
                if (done8 !== 1'b0 || busy8 !== 1'b1) begin
                    n_mismatched++;
                    $display("FAIL %s run_cycle%0d: got done=%b busy=%b want done=0 busy=1",
                             name, c, done8, busy8);
                end
                n_compared++;
                if (diff8 !== prev_d || borrow8 !== prev_b) begin
                    n_mismatched++;
                    $display("FAIL %s hold_cycle%0d: got diff=%h borrow=%b want diff=%h borrow=%b",
                             name, c, diff8, borrow8, prev_d, prev_b);
                end
            end else begin
                n_compared++;
                if (done8 !== 1'b1 || busy8 !== 1'b1) begin
                    n_mismatched++;
                    $display("FAIL %s done_cycle: got done=%b busy=%b want done=1 busy=1",
                             name, done8, busy8);
                end
                n_compared++;
                if (diff8 !== ed || borrow8 !== eb) begin
                    n_mismatched++;
                    $display("FAIL %s result: got diff=%h borrow=%b want diff=%h borrow=%b",
                             name, diff8, borrow8, ed, eb);
                end
            end
        end
        tick();
        n_compared++;
        if (done8 !== 1'b0 || busy8 !== 1'b0 || diff8 !== ed || borrow8 !== eb) begin
            n_mismatched++;
            $display("FAIL %s after_done: got done=%b busy=%b diff=%h borrow=%b want 0 0 %h %b",
                     name, done8, busy8, diff8, borrow8, ed, eb);
        end
        prev_d = ed;
        prev_b = eb;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start16 = 1'b0; a16 = '0; b16 = '0;
        #3;
        // No clock edge has happened yet: reset alone must clear outputs.
        n_compared++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || diff8 !== 8'h00 || borrow8 !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reset_w8: got busy=%b done=%b diff=%h borrow=%b want all 0",
                     busy8, done8, diff8, borrow8);
        end
        n_compared++;
        if (busy16 !== 1'b0 || done16 !== 1'b0 || diff16 !== 16'h0 || borrow16 !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reset_w16: got busy=%b done=%b diff=%h borrow=%b want all 0",
                     busy16, done16, diff16, borrow16);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_compared++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reset_release: got busy=%b done=%b want 0 0", busy8, done8);
        end
    endtask

    task automatic test_basic();
        run_op8(8'd100, 8'd37, 1'b0, "basic_100_37");
    endtask

    task automatic test_boundaries();
        run_op8(8'd5,   8'd9,   1'b0, "under_5_9");
        run_op8(8'd0,   8'd255, 1'b0, "zero_minus_255");
        run_op8(8'hA5,  8'hA5,  1'b0, "equal_a5");
        run_op8(8'd77,  8'd0,   1'b0, "minus_zero");
        run_op8(8'd255, 8'd1,   1'b0, "max_minus_1");
    endtask

    task automatic test_ignore_start();
        int n_done;
        logic [7:0] got_d;
        logic       got_b;
        n_done = 0;
        got_d  = 8'hxx;
        got_b  = 1'bx;
        start8 = 1'b1; a8 = 8'd50; b8 = 8'd20;
        tick();
        start8 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 3) begin
                start8 = 1'b1; a8 = 8'd1; b8 = 8'd2;
            end else begin
                start8 = 1'b0;
            end
            if (done8 === 1'b1) begin
                n_done++;
                got_d = diff8;
                got_b = borrow8;
            end
        end
        n_compared++;
        if (n_done != 1) begin
            n_mismatched++;
            $display("FAIL ignore_start done_count: got %0d want 1", n_done);
        end
        n_compared++;
        if (got_d !== 8'd30 || got_b !== 1'b0) begin
            n_mismatched++;
            $display("FAIL ignore_start result: got diff=%h borrow=%b want diff=1e borrow=0",
                     got_d, got_b);
        end
        n_compared++;
        if (busy8 !== 1'b0) begin
            n_mismatched++;
            $display("FAIL ignore_start idle: got busy=%b want 0", busy8);
        end
        prev_d = 8'd30;
        prev_b = 1'b0;
    endtask

    task automatic test_operand_toggle();
        run_op8(8'd200, 8'd201, 1'b1, "toggle_200_201");
        for (int c = 0; c < 3; c++) begin
            tick();
            n_compared++;
            if (diff8 !== 8'hFF || borrow8 !== 1'b1) begin
                n_mismatched++;
                $display("FAIL toggle_idle_hold%0d: got diff=%h borrow=%b want diff=ff borrow=1",
                         c, diff8, borrow8);
            end
        end
        // Back-to-back: next op starts in the first idle cycle; run_op8
        // also checks the previous result holds throughout RUN.
        run_op8(8'd7, 8'd3, 1'b0, "b2b_7_3");
        run_op8(8'd3, 8'd7, 1'b1, "b2b_3_7");
    endtask

    task automatic test_async_reset();
        int n_done;
        n_done = 0;
        start8 = 1'b1; a8 = 8'd100; b8 = 8'd37;
        tick();
        start8 = 1'b0;
        for (int c = 1; c <= 4; c++) tick();
        #2;
        rst = 1'b1;
        #1;
        n_compared++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || diff8 !== 8'h00 || borrow8 !== 1'b0) begin
            n_mismatched++;
            $display("FAIL async_reset: got busy=%b done=%b diff=%h borrow=%b want all 0",
                     busy8, done8, diff8, borrow8);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done8 !== 1'b0 || busy8 !== 1'b0) n_done++;
        end
        n_compared++;
        if (n_done != 0) begin
            n_mismatched++;
            $display("FAIL async_reset abort: got %0d busy/done cycles want 0", n_done);
        end
        prev_d = 8'h00;
        prev_b = 1'b0;
        run_op8(8'd200, 8'd55, 1'b0, "post_reset_200_55");
    endtask

    task automatic test_random8();
        int guard;
        logic [7:0] a, b, ed;
        logic       eb;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            ed = a - b;
            eb = (a < b);
            start8 = 1'b1; a8 = a; b8 = b;
            tick();
            start8 = 1'b0;
            guard = 0;
            while (done8 !== 1'b1 && guard < 40) begin
                tick();
                guard++;
            end
            n_compared++;
            if (guard != 8) begin
                n_mismatched++;
                $display("FAIL rand8[%0d] latency: got %0d want 8", i, guard);
                break;
            end
            n_compared++;
            if (diff8 !== ed || borrow8 !== eb) begin
                n_mismatched++;
                $display("FAIL rand8[%0d] a=%h b=%h: got diff=%h borrow=%b want diff=%h borrow=%b",
                         i, a, b, diff8, borrow8, ed, eb);
            end
            tick();
        end
    endtask

    task automatic test_random16();
        int guard;
        logic [15:0] a, b, ed;
        logic        eb;
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (i == 0) b = a;
            if (i == 1) a = 16'h0;
            ed = a - b;
            eb = (a < b);
            start16 = 1'b1; a16 = a; b16 = b;
            tick();
            start16 = 1'b0;
            guard = 0;
            while (done16 !== 1'b1 && guard < 60) begin
                tick();
                guard++;
            end
            n_compared++;
            if (guard != 16) begin
                n_mismatched++;
                $display("FAIL rand16[%0d] latency: got %0d want 16", i, guard);
                break;
            end
            n_compared++;
            if (diff16 !== ed || borrow16 !== eb) begin
                n_mismatched++;
                $display("FAIL rand16[%0d] a=%h b=%h: got diff=%h borrow=%b want diff=%h borrow=%b",
                         i, a, b, diff16, borrow16, ed, eb);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_ignore_start();
        test_operand_toggle();
        test_async_reset();
        test_random8();
        test_random16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
